// File: rtl/reg_desloc_ctrl.sv
// reg_desloc_ctrl -- command sequencer for the reg_desloc shift register.
//
// A command (data word, direction, shift count) is accepted on a rising edge
// where ready=1 and start=1. The block then drives reg_desloc for one LOAD
// cycle and `count` SHIFT cycles, and finishes with a one-cycle done pulse.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   start      command valid
//   cmd_data   word to load (WIDTH bits)
//   cmd_dir    0 = shift left, 1 = shift right
//   cmd_count  number of shift cycles after the load (CNT_W bits)
//   ready      idle, able to accept a command
//   busy       LOAD or SHIFT in progress
//   done       one-cycle completion pulse
//   sh_enable  reg_desloc enable
//   sh_select  reg_desloc select: 00 load, 01 left, 10 right, 11 hold
//   sh_data    reg_desloc data (captured word)
//   dbg_state  current FSM state (0 IDLE, 1 LOAD, 2 SHIFT, 3 DONE)
//
// Optional feature, macro REG_DESLOC_CTRL_ABORT_EN:
//   abort      (input)  ends LOAD/SHIFT early; done follows one cycle later
//   aborted    (output) high together with done for an aborted command
//
// Handshake: start/ready follow valid/ready semantics -- a command transfers
// on a rising edge where start=1 and ready=1; start at any other time is
// ignored, nothing is queued, and cmd_* are sampled only on that edge.
//
// All outputs are decoded purely from flops (state and captured command),
// so they only change right after a clock edge or on reset.

module reg_desloc_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef REG_DESLOC_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             sh_enable,
  output logic [1:0]       sh_select,
  output logic [WIDTH-1:0] sh_data,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             abort_req;

`ifdef REG_DESLOC_CTRL_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // State register and captured command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      count_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      rem_q   <= rem_d;
    end
  end

`ifdef REG_DESLOC_CTRL_ABORT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    count_d = count_q;
    rem_d   = rem_q;
`ifdef REG_DESLOC_CTRL_ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef REG_DESLOC_CTRL_ABORT_EN
        aborted_d = 1'b0;
`endif
        if (start) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          count_d = cmd_count;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rem_d = count_q;
`ifdef REG_DESLOC_CTRL_ABORT_EN
        aborted_d = abort_req;
`endif
        if (abort_req || (count_q == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // rem_q is at least 1 here, so the decrement cannot wrap.
        rem_d = rem_q - CNT_W'(1);
`ifdef REG_DESLOC_CTRL_ABORT_EN
        aborted_d = abort_req;
`endif
        if (abort_req || (rem_q == CNT_W'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    sh_enable = 1'b0;
    sh_select = 2'b11;
    sh_data   = data_q;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
      end
      S_LOAD: begin
        busy      = 1'b1;
        sh_enable = 1'b1;
        sh_select = 2'b00;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        sh_enable = 1'b1;
        sh_select = dir_q ? 2'b10 : 2'b01;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

`ifdef REG_DESLOC_CTRL_ABORT_EN
  assign aborted = aborted_q;
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_desloc_ctrl.sv
module tb_reg_desloc_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             abort = 1'b0;

  logic             ready, busy, done, sh_enable;
  logic [1:0]       sh_select;
  logic [WIDTH-1:0] sh_data;
  logic [1:0]       dbg_state;
  logic             aborted_w;

  reg_desloc_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
`ifdef REG_DESLOC_CTRL_ABORT_EN
    .abort     (abort),
    .aborted   (aborted_w),
`endif
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sh_enable (sh_enable),
    .sh_select (sh_select),
    .sh_data   (sh_data),
    .dbg_state (dbg_state)
  );

`ifndef REG_DESLOC_CTRL_ABORT_EN
  assign aborted_w = 1'b0;
`endif

  // ---------------- counters / check ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected outputs of one cycle.
  typedef struct packed {
    logic             ready;
    logic             busy;
    logic             done;
    logic             en;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
    logic             ab;
  } exp_t;

  function automatic exp_t mk(input logic r, input logic b, input logic d, input logic e,
                              input logic [1:0] s, input logic [WIDTH-1:0] w, input logic a);
    exp_t x;
    x.ready = r; x.busy = b; x.done = d; x.en = e; x.sel = s; x.data = w; x.ab = a;
    return x;
  endfunction

  // Schedule of expected outputs for the cycles still to come in a command.
  exp_t             exp_q[$];
  exp_t             m_cur = '{ready: 1'b1, busy: 1'b0, done: 1'b0, en: 1'b0,
                              sel: 2'b11, data: '0, ab: 1'b0};
  logic [WIDTH-1:0] m_data = '0;

  always @(posedge clk or negedge rst) begin
    exp_t             nxt;
    logic [WIDTH-1:0] d;
    if (!rst) begin
      exp_q.delete();
      m_data <= '0;
      m_cur  <= mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, '0, 1'b0);
    end else begin
      d = m_data;
      if (m_cur.ready && start) begin
        // A command becomes: 1 load cycle, count shift cycles, 1 done cycle.
        d = cmd_data;
        exp_q.delete();
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, d, 1'b0));
        for (int i = 0; i < int'(cmd_count); i++)
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, cmd_dir ? 2'b10 : 2'b01, d, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, d, 1'b0));
      end else if (m_cur.busy && abort) begin
        exp_q.delete();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, d, 1'b1));
      end
      if (exp_q.size() > 0) nxt = exp_q.pop_front();
      else                  nxt = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, d, 1'b0);
      m_data <= d;
      m_cur  <= nxt;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cycle_outputs",
        32'({ready, busy, done, sh_enable, sh_select, sh_data, aborted_w}),
        32'(m_cur));
  end

  // Stand-in for reg_desloc, zero fill, driven by the DUT's pins.
  logic [WIDTH-1:0] sr = '0;
  always @(negedge clk) begin
    if (sh_enable) begin
      case (sh_select)
        2'b00:   sr <= sh_data;
        2'b01:   sr <= sr << 1;
        2'b10:   sr <= sr >> 1;
        default: sr <= sr;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 2 time units after a rising edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic dir, input logic [CNT_W-1:0] c);
    int n = 0;
    while (!m_cur.ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) chk("send_ready_timeout", 32'(n), 32'(0));
    start = 1'b1; cmd_data = d; cmd_dir = dir; cmd_count = c;
    @(posedge clk); #2;
    // Later changes to cmd_* must have no effect.
    start = 1'b0; cmd_data = ~d; cmd_dir = ~dir; cmd_count = ~c;
  endtask

  int               n_done;
  logic [1:0]       first_sel;
  logic [WIDTH-1:0] first_data;
  int               left_cnt, right_cnt;

  task automatic run_until_done();
    int n = 0;
    left_cnt = 0; right_cnt = 0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) begin first_sel = sh_select; first_data = sh_data; end
      if (sh_enable && sh_select == 2'b01) left_cnt++;
      if (sh_enable && sh_select == 2'b10) right_cnt++;
      if (done || n >= 40) break;
    end
    if (n >= 40) chk("done_timeout", 32'(done), 32'(1));
    n_done = n;
    @(posedge clk); #2;
  endtask

  task automatic chk_idle_literal(input string name);
    chk({name, "_ready"}, 32'(ready), 32'(1));
    chk({name, "_busy"},  32'(busy),  32'(0));
    chk({name, "_done"},  32'(done),  32'(0));
    chk({name, "_en"},    32'(sh_enable), 32'(0));
    chk({name, "_sel"},   32'(sh_select), 32'(3));
    chk({name, "_data"},  32'(sh_data),   32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p1, p2, n, dones;

    // Reset asserted from time 0; check mid-clock.
    #3;
    chk_idle_literal("reset");
    chk("reset_state", 32'(dbg_state), 32'(0));
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    // Load + left, count 2.
    send(4'b1010, 1'b0, 3'd2);
    run_until_done();
    chk("left_load_sel",  32'(first_sel),  32'(2'b00));
    chk("left_load_data", 32'(first_data), 32'(4'b1010));
    chk("left_latency",   32'(n_done),     32'(4));
    chk("left_shifts",    32'(left_cnt),   32'(2));
    chk("left_sr",        32'(sr),         32'(4'b1000));
    chk("left_ready_back", 32'(ready),     32'(1));

    // Right, max count.
    send(4'b0110, 1'b1, 3'd7);
    run_until_done();
    chk("right_latency", 32'(n_done),    32'(9));
    chk("right_shifts",  32'(right_cnt), 32'(7));
    chk("right_sr",      32'(sr),        32'(4'b0000));

    // Count 0: load only.
    send(4'b1111, 1'b0, 3'd0);
    run_until_done();
    chk("zero_latency", 32'(n_done),   32'(2));
    chk("zero_shifts",  32'(left_cnt + right_cnt), 32'(0));
    chk("zero_sr",      32'(sr),       32'(4'b1111));

    // Start pulsed during SHIFT is ignored.
    send(4'b0001, 1'b0, 3'd3);
    @(posedge clk); #2;
    start = 1'b1; cmd_data = 4'b0011; cmd_dir = 1'b1; cmd_count = 3'd1;
    @(posedge clk); #2;
    start = 1'b0;
    run_until_done();
    chk("ignore_latency", 32'(n_done), 32'(3));
    chk("ignore_sr",      32'(sr),     32'(4'b1000));

    // Back-to-back: start held high, second command taken when ready rises.
    start = 1'b1; cmd_data = 4'b1001; cmd_dir = 1'b1; cmd_count = 3'd2;
    p1 = 0; p2 = 0; n = 0;
    while (p2 == 0 && n < 30) begin
      @(negedge clk);
      n++;
      if (sh_enable && sh_select == 2'b00) begin
        if (p1 == 0) p1 = n;
        else         p2 = n;
      end
    end
    @(posedge clk); #2;
    start = 1'b0;
    chk("b2b_spacing", 32'(p2 - p1), 32'(5));
    run_until_done();
    chk("b2b_sr", 32'(sr), 32'(4'b0010));

    // Reset in the middle of SHIFT.
    send(4'b1011, 1'b0, 3'd5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_idle_literal("midreset");
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midreset_no_done", 32'(dones), 32'(0));
    @(posedge clk); #2;
    rst = 1'b1;
    send(4'b0111, 1'b1, 3'd1);
    run_until_done();
    chk("after_reset_latency", 32'(n_done), 32'(3));
    chk("after_reset_sr",      32'(sr),     32'(4'b0011));

`ifdef REG_DESLOC_CTRL_ABORT_EN
    // Abort on the third shift cycle.
    send(4'b0001, 1'b0, 3'd6);
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_done",    32'(done),      32'(1));
    chk("abort_aborted", 32'(aborted_w), 32'(1));
    @(posedge clk); #2;
    chk("abort_sr",      32'(sr),        32'(4'b1000));
    chk("abort_ready",   32'(ready),     32'(1));
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/reg_desloc_ctrl.md
Name: reg_desloc_ctrl

Overview:
- Command sequencer for the reg_desloc shift register.
- Accepts one command per handshake: a data word, a direction and a shift count.
- Drives reg_desloc's enable/select/data pins to load the word, then shifts it N times, then reports completion.
- Sits between the datapath control unit and reg_desloc; reg_desloc's output is not read by this block.

Parameters:
- WIDTH, 4, data width of the shift register and of cmd_data/sh_data.
- CNT_W, 3, width of cmd_count; maximum shift count is 2**CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- start  input  1  command valid; accepted only on a rising edge where ready=1.
- cmd_data  input  WIDTH  word to load into reg_desloc.
- cmd_dir  input  1  0 = shift left, 1 = shift right.
- cmd_count  input  CNT_W  number of shift cycles after the load.
- ready  output  1  block idle and able to accept a command.
- busy  output  1  command in progress (LOAD or SHIFT state).
- done  output  1  one-cycle completion pulse.
- sh_enable  output  1  to reg_desloc enable.
- sh_select  output  2  to reg_desloc select: 00 load, 01 shift left, 10 shift right, 11 hold.
- sh_data  output  WIDTH  to reg_desloc data.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on port rst.
- All outputs registered (Moore), decoded from state and captured command registers.
- States: IDLE, LOAD, SHIFT, DONE.
- Reset (rst=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, sh_enable=0, sh_select=11, sh_data=0, internal cmd/count registers=0.
- IDLE: ready=1, sh_enable=0, sh_select=11.
  - On an edge with start=1, capture cmd_data, cmd_dir and cmd_count, then go to LOAD.
  - start while not in IDLE is ignored; no queueing.
- LOAD (exactly 1 cycle): busy=1, sh_enable=1, sh_select=00, sh_data=captured data.
  - Next state is DONE if count==0, else SHIFT with remaining=count.
- SHIFT: busy=1, sh_enable=1, sh_select=01 if dir=0, 10 if dir=1.
  - sh_data keeps the captured word, unused by reg_desloc.
  - remaining decrements each cycle; on the cycle where remaining==1, next state is DONE.
  - Exactly count SHIFT cycles occur.
- DONE (1 cycle): done=1, busy=0, ready=0, sh_enable=0, sh_select=11; next state IDLE.
- Latency: command accepted at edge k.
  - LOAD outputs are visible in cycle k+1.
  - done is high in cycle k+2+count.
  - ready returns in cycle k+3+count.
- Back-to-back: start held high through DONE is accepted on the first edge where ready=1. Minimum command spacing is count+3 cycles.
- Count limits: count=0 gives load only; count=2**CNT_W-1 is the maximum. The remaining counter never wraps.
- Reset mid-operation: return to IDLE at once, sh_enable drops the same instant, and no done pulse is produced.
- Inputs cmd_* are sampled only on the accepting edge; later changes have no effect.

Optional Feature:
- Macro: REG_DESLOC_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in LOAD or SHIFT forces the next state to DONE, so done pulses one cycle later; the shift in the current cycle completes.
  - Adds output aborted (1 bit), high together with done only for an aborted command, 0 at reset.
  - abort in IDLE or DONE is ignored.
- Undefined: neither port exists, and commands always run to completion.

Test Plan:
- Reset: rst=0 mid-clock -> immediately ready=1, busy=0, done=0, sh_enable=0, sh_select=11, sh_data=0.
- Load+left: cmd_data=1010, dir=0, count=2, start 1 cycle -> one cycle sel=00/data=1010, then 2 cycles sel=01 enable=1, then done=1 for 1 cycle, then ready=1. Total 4 cycles from acceptance to done inclusive.
- Right, max count: data=0110, dir=1, count=7 -> 1 LOAD cycle + exactly 7 cycles sel=10, then done. Reg_desloc output checked against a model.
- Count 0: data=1111, count=0 -> LOAD one cycle, done next cycle, no shift cycles.
- Ignored start and back-to-back: pulse start during SHIFT with different data -> no effect on sh_data or sequence. Start held high -> second command accepted on the cycle ready rises.
- Reset mid-SHIFT (count=5, after 2 shifts): rst=0 -> sh_enable=0 immediately, no done. After release, a new command runs normally.
  - With REG_DESLOC_CTRL_ABORT_EN, also: abort at the 3rd shift -> done and aborted high one cycle later, 3 shift cycles total.
